// File: rtl/rtc_text_fmt_pkg.sv
// Package rtc_disp_pkg: shared types and constants for the RTC text formatter.
//   - fmt_state_t      : render FSM states
//   - cell constants   : line bases and fixed cell positions in the 48-cell buffer
//   - ASCII constants  : glyphs used by the renderer
//   - timer_char()     : character n (0..4) of the "TIMER" banner
package rtc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_WRITE = 2'd2,
        ST_SWAP  = 2'd3
    } fmt_state_t;

    localparam int unsigned NUM_CELLS = 48;
    localparam logic [5:0]  LAST_CELL = 6'd47;

    // Line identifiers used while rendering
    localparam logic [1:0] LINE_TIME   = 2'd0;
    localparam logic [1:0] LINE_DATE   = 2'd1;
    localparam logic [1:0] LINE_CHRONO = 2'd2;

    localparam logic [5:0] LINE0_BASE = 6'd0;
    localparam logic [5:0] LINE1_BASE = 6'd16;
    localparam logic [5:0] LINE2_BASE = 6'd32;

    // Separator columns inside a "xx:xx:xx" group
    localparam logic [3:0] COL_SEP_A = 4'd2;
    localparam logic [3:0] COL_SEP_B = 4'd5;

    localparam logic [5:0] CELL_COLON_A     = LINE0_BASE + 6'(COL_SEP_A);
    localparam logic [5:0] CELL_COLON_B     = LINE0_BASE + 6'(COL_SEP_B);
    localparam logic [5:0] CELL_AM_PM       = LINE0_BASE + 6'd9;
    localparam logic [5:0] CELL_M           = LINE0_BASE + 6'd10;
    localparam logic [5:0] CELL_TIMER_FIRST = LINE2_BASE + 6'd9;
    localparam logic [5:0] CELL_TIMER_LAST  = LINE2_BASE + 6'd13;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_M     = 8'h4D;
    localparam logic [39:0] STR_TIMER = "TIMER";

    function automatic logic [7:0] timer_char(input logic [2:0] idx);
        logic [7:0] c;
        c = STR_TIMER[39:32];
        case (idx)
            3'd0:    c = STR_TIMER[39:32];
            3'd1:    c = STR_TIMER[31:24];
            3'd2:    c = STR_TIMER[23:16];
            3'd3:    c = STR_TIMER[15:8];
            default: c = STR_TIMER[7:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_text_fmt_if.sv
// Interface bundling the reader-side inputs and the display-side read port
// of rtc_text_fmt.
//   master : driver side (RTC reader + VGA text renderer)
//   slave  : the formatter itself
interface rtc_text_fmt_if;

    logic       upd;
    logic [7:0] hora;
    logic [7:0] min;
    logic [7:0] seg;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] horacrono;
    logic [7:0] mincrono;
    logic [7:0] segcrono;
    logic       AmPm;
    logic       timer;
    logic       blink_tick;
    logic [5:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy;
    logic       frame_ready;
    logic       alarm;

    modport master (
        output upd, hora, min, seg, dia, mes, year,
               horacrono, mincrono, segcrono, AmPm, timer,
               blink_tick, rd_addr,
        input  rd_char, busy, frame_ready, alarm
    );

    modport slave (
        input  upd, hora, min, seg, dia, mes, year,
               horacrono, mincrono, segcrono, AmPm, timer,
               blink_tick, rd_addr,
        output rd_char, busy, frame_ready, alarm
    );

endinterface

// File: rtl/rtc_text_fmt_bcd_to_ascii.sv
// bcd_to_ascii: converts one BCD nibble to its ASCII digit.
//   nibble : 4-bit BCD digit
//   ascii  : '0'..'9', or ERRCH when nibble > 9
module bcd_to_ascii
    import rtc_disp_pkg::*;
#(
    parameter logic [7:0] ERRCH = 8'h3F
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble > 4'd9) ? ERRCH : (ASC_0 + {4'h0, nibble});

endmodule

// File: rtl/rtc_text_fmt.sv
// rtc_text_fmt: snapshots the RTC reader outputs and renders them into a
// double-banked 48-cell ASCII buffer (3 lines x 16 cells).
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : rtc_text_fmt_if.slave
//           in : upd, hora/min/seg, dia/mes/year, chrono fields, AmPm,
//                timer, blink_tick, rd_addr
//           out: rd_char (1-cycle latency), busy, frame_ready, alarm
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for an upd rising edge
// ST_SNAP  | latch all inputs into shadow registers
// ST_WRITE | render cells 0..47 into the inactive bank, one per cycle
// ST_SWAP  | flip active bank, pulse frame_ready, update alarm
module rtc_text_fmt
    import rtc_disp_pkg::*;
#(
    parameter logic [7:0] BLANK    = 8'h20,
    parameter logic [7:0] ERRCH    = 8'h3F,
    parameter bit         BLINK_EN = 1'b1
) (
    input logic           clock,
    input logic           reset,
    rtc_text_fmt_if.slave bus
);

    fmt_state_t state_q, state_d;
    logic       pending_q, pending_d;
    logic       snap_c, write_c, swap_c, busy_c;

    logic       upd_q;
    logic       upd_edge;

    logic [5:0] cell_q;
    logic       bank_q;
    logic       phase_q;
    logic       alarm_q;
    logic [7:0] rd_char_q;
    logic [7:0] rd_data_c;

    // Shadow snapshot; rendering reads only these
    logic       hour_inv_s;
    logic [5:0] hora_s;
    logic [7:0] min_s, seg_s, dia_s, mes_s, year_s;
    logic [5:0] hc_s;
    logic [7:0] mc_s, sc_s;
    logic       ampm_s, timer_s;

    logic [7:0] bank0 [0:NUM_CELLS-1];
    logic [7:0] bank1 [0:NUM_CELLS-1];

    logic [1:0] line_c;
    logic [3:0] col_c;
    logic [1:0] fsel_c;
    logic [7:0] field_c;
    logic [7:0] tens_chr, units_chr, digit_c, cell_chr;
    logic       is_tens_c;

    // Hour bit 6 and chrono-hour bits 7:6 carry no information
    logic unused_bits;
    assign unused_bits = ^{bus.hora[6], bus.horacrono[7:6]};

    assign upd_edge = bus.upd & ~upd_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        snap_c    = 1'b0;
        write_c   = 1'b0;
        swap_c    = 1'b0;
        busy_c    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (upd_edge || pending_q) begin
                    state_d   = ST_SNAP;
                    pending_d = 1'b0;
                end
            end
            ST_SNAP: begin
                snap_c  = 1'b1;
                state_d = ST_WRITE;
                if (upd_edge) pending_d = 1'b1;
            end
            ST_WRITE: begin
                write_c = 1'b1;
                if (upd_edge) pending_d = 1'b1;
                if (cell_q == LAST_CELL) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                swap_c = 1'b1;
                // An edge arriving in the swap cycle itself must not be lost
                if (pending_q || upd_edge) begin
                    state_d   = ST_SNAP;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot, cell counter, bank select, blink, alarm, read port
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upd_q      <= 1'b0;
            cell_q     <= '0;
            bank_q     <= 1'b0;
            phase_q    <= 1'b1;
            alarm_q    <= 1'b0;
            rd_char_q  <= BLANK;
            hour_inv_s <= 1'b1;
            hora_s     <= '0;
            min_s      <= '0;
            seg_s      <= '0;
            dia_s      <= '0;
            mes_s      <= '0;
            year_s     <= '0;
            hc_s       <= '0;
            mc_s       <= '0;
            sc_s       <= '0;
            ampm_s     <= 1'b0;
            timer_s    <= 1'b0;
        end else begin
            upd_q     <= bus.upd;
            rd_char_q <= rd_data_c;
            if (bus.blink_tick) phase_q <= ~phase_q;
            if (snap_c) begin
                hour_inv_s <= bus.hora[7];
                hora_s     <= bus.hora[5:0];
                min_s      <= bus.min;
                seg_s      <= bus.seg;
                dia_s      <= bus.dia;
                mes_s      <= bus.mes;
                year_s     <= bus.year;
                hc_s       <= bus.horacrono[5:0];
                mc_s       <= bus.mincrono;
                sc_s       <= bus.segcrono;
                ampm_s     <= bus.AmPm;
                timer_s    <= bus.timer;
                cell_q     <= '0;
            end
            if (write_c) cell_q <= cell_q + 6'd1;
            if (swap_c) begin
                bank_q  <= ~bank_q;
                alarm_q <= timer_s;
            end
        end
    end

    // Render always targets the bank that is not being displayed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                bank0[i] <= BLANK;
                bank1[i] <= BLANK;
            end
        end else if (write_c) begin
            if (bank_q) bank0[cell_q] <= cell_chr;
            else        bank1[cell_q] <= cell_chr;
        end
    end

    always_comb begin
        rd_data_c = BLANK;
        if (bus.rd_addr <= LAST_CELL) begin
            rd_data_c = bank_q ? bank1[bus.rd_addr] : bank0[bus.rd_addr];
        end
        if (BLINK_EN && !phase_q &&
            (bus.rd_addr == CELL_COLON_A || bus.rd_addr == CELL_COLON_B)) begin
            rd_data_c = BLANK;
        end
    end

    // ------------------------------------------------------------------
    // Cell renderer
    // ------------------------------------------------------------------
    always_comb begin
        line_c = LINE_TIME;
        col_c  = 4'(cell_q - LINE0_BASE);
        if (cell_q >= LINE2_BASE) begin
            line_c = LINE_CHRONO;
            col_c  = 4'(cell_q - LINE2_BASE);
        end else if (cell_q >= LINE1_BASE) begin
            line_c = LINE_DATE;
            col_c  = 4'(cell_q - LINE1_BASE);
        end

        // Group 0 = cols 0-1, group 1 = cols 3-4, group 2 = cols 6-7
        fsel_c = 2'd0;
        if (col_c >= 4'd6)      fsel_c = 2'd2;
        else if (col_c >= 4'd3) fsel_c = 2'd1;

        field_c = 8'h00;
        case ({line_c, fsel_c})
            {LINE_TIME,   2'd0}: field_c = {2'b00, hora_s};
            {LINE_TIME,   2'd1}: field_c = min_s;
            {LINE_TIME,   2'd2}: field_c = seg_s;
            {LINE_DATE,   2'd0}: field_c = dia_s;
            {LINE_DATE,   2'd1}: field_c = mes_s;
            {LINE_DATE,   2'd2}: field_c = year_s;
            {LINE_CHRONO, 2'd0}: field_c = {2'b00, hc_s};
            {LINE_CHRONO, 2'd1}: field_c = mc_s;
            {LINE_CHRONO, 2'd2}: field_c = sc_s;
            default:             field_c = 8'h00;
        endcase
    end

    bcd_to_ascii #(.ERRCH(ERRCH)) u_tens (
        .nibble (field_c[7:4]),
        .ascii  (tens_chr)
    );

    bcd_to_ascii #(.ERRCH(ERRCH)) u_units (
        .nibble (field_c[3:0]),
        .ascii  (units_chr)
    );

    always_comb begin
        is_tens_c = (col_c == 4'd0) || (col_c == 4'd3) || (col_c == 4'd6);
        digit_c   = is_tens_c ? tens_chr : units_chr;

        cell_chr = BLANK;
        case (col_c)
            4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7: cell_chr = digit_c;
            COL_SEP_A, COL_SEP_B:
                cell_chr = (line_c == LINE_DATE) ? ASC_SLASH : ASC_COLON;
            default: cell_chr = BLANK;
        endcase

        if (line_c == LINE_TIME && col_c <= 4'd1 && hour_inv_s) cell_chr = ASC_DASH;
        if (cell_q == CELL_AM_PM) cell_chr = hour_inv_s ? BLANK : (ampm_s ? ASC_P : ASC_A);
        if (cell_q == CELL_M)     cell_chr = hour_inv_s ? BLANK : ASC_M;
        if (timer_s && cell_q >= CELL_TIMER_FIRST && cell_q <= CELL_TIMER_LAST) begin
            cell_chr = timer_char(3'(cell_q - CELL_TIMER_FIRST));
        end
    end

    assign bus.rd_char     = rd_char_q;
    assign bus.busy        = busy_c;
    assign bus.frame_ready = swap_c;
    assign bus.alarm       = alarm_q;

endmodule

// File: doc/rtc_text_fmt.md
Name: rtc_text_fmt

Overview:
Downstream consumer of the RTC register reader. It captures the reader's BCD time, date, chrono, AM/PM and timer outputs as one snapshot and renders them into a 48-character ASCII text buffer. The buffer is double-banked, so the VGA text renderer always reads a consistent frame through a registered read port. Blinking colons and an alarm flag are produced here.

Parameters:
BLANK, 8'h20, ASCII code written to unused cells
ERRCH, 8'h3F, ASCII code for a non-BCD nibble ('?')
BLINK_EN, 1, 1 = colons in line 0 blank while blink phase is 0

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
upd  in  1  snapshot request; level, rising-edge detected (driven from the reader's chs)
hora  in  8  BCD hour; bit7=1 means hour not yet read
min,seg,dia,mes,year  in  8 each  BCD fields
horacrono,mincrono,segcrono  in  8 each  BCD chrono fields
AmPm  in  1  1 = PM
timer  in  1  timer-expired flag
blink_tick  in  1  one-cycle pulse; toggles blink phase
rd_addr  in  6  character index 0..47, values 48..63 are out of range
rd_char  out  8  ASCII at rd_addr, 1-cycle latency
busy  out  1  render in progress
frame_ready  out  1  one-cycle pulse on bank swap
alarm  out  1  registered snapshot of timer

Behaviour:
- Reset (reset=0, async): all buffer cells in both banks = BLANK; rd_char=BLANK; busy=0; frame_ready=0; alarm=0; bank=0; blink phase=1; pending=0; FSM=IDLE.
- Layout, line 0 (cells 0-15): "HH:MM:SS", then space, "AM"/"PM" at cells 9-10, BLANK at 11-15.
- Layout, line 1 (cells 16-31): "DD/MM/YY", BLANK at 24-31.
- Layout, line 2 (cells 32-47): chrono "HH:MM:SS" at 32-39; BLANK at 40; "TIMER" at 41-45 if the timer snapshot is 1, else BLANK; BLANK at 46-47.
- Digit order: tens nibble first (bits[7:4], then bits[3:0]). hora and horacrono use only bits[5:0]; their tens digit comes from bits[5:4] zero-extended.
- Hour invalid: if snapshot hora[7]=1, cells 0-1 = "--" and cells 9-10 = BLANK.
- Any nibble above 9 renders as ERRCH.
- FSM states:
  - IDLE: upd rising edge -> SNAP.
  - SNAP: 1 cycle; latch all inputs into shadow registers; busy=1.
  - WRITE: 48 cycles; cell index 0..47, one cell per cycle, written into the inactive bank.
  - SWAP: 1 cycle; toggle bank, frame_ready=1, alarm <= shadow timer. Go to SNAP if pending (then clear pending), else IDLE.
- Latency: upd edge sampled at cycle N -> SNAP at N+1, writes N+2..N+49, SWAP at N+50. rd_char shows the new frame from cycle N+51.
- An upd edge seen during SNAP, WRITE or SWAP sets pending. Multiple edges collapse into one pending request. Inputs are never re-sampled mid-render.
- Read port:
  - rd_char <= active-bank[rd_addr] each cycle.
  - rd_addr >= 48 returns BLANK.
  - If BLINK_EN=1, blink phase=0 and rd_addr is 2 or 5, return BLANK.
  - A read in the swap cycle returns the old bank's data.
- blink_tick toggles the phase in any state. Simultaneous blink_tick and a swap are independent.
- Reset asserted mid-render aborts immediately. Both banks clear to BLANK and pending is lost.

Decomposition:
- Package rtc_disp_pkg:
  - FSM state enum (IDLE, SNAP, WRITE, SWAP).
  - Cell-position constants: line bases 0/16/32, colon cells, AM/PM cells, TIMER cells.
  - ASCII constants: '0', ':', '/', '-', 'A', 'P', 'M', and the string "TIMER".
- Sub-module bcd_to_ascii: 4-bit nibble -> 8-bit ASCII; outputs ERRCH when the nibble is above 9. Two instances (tens, units), muxed by the cell index.

Test Plan:
1. Reset, then read all 64 addresses -> every rd_char = 8'h20; busy=0; alarm=0.
2. hora=8'h12, min=8'h34, seg=8'h56, AmPm=1, upd pulse -> frame_ready exactly 50 cycles after the sampled edge; cells 0-10 read "12:34:56 PM".
3. dia=8'h07, mes=8'h11, year=8'h16, chrono 00:01:30, timer=1 -> cells 16-23 read "07/11/16"; cells 32-39 read "00:01:30"; cells 41-45 read "TIMER"; alarm=1 after the swap.
4. hora=8'h80 (reset value), min=8'h3A -> cells 0-1 read "--"; cell 4 = 8'h3F; cells 9-10 blank.
5. Second upd edge at write cycle 10, with the inputs changed after that edge -> first frame still holds the old values; a second frame_ready follows 50 cycles later with the new values; a third edge during the second render yields exactly one more frame.
6. blink_tick pulse with BLINK_EN=1 -> reads of cells 2 and 5 return 8'h20 while cell 2 in the buffer holds ':'; the next tick restores ':'. Async reset at write cycle 20 -> busy=0 and all cells blank at the next read.
